division: RTL

Sequential 8-bit unsigned restoring divider for the ALU. It is the inverse companion of the combinational multiply path: it accepts dividend A and divisor B on a start pulse, produces the quotient and remainder one bit per clock, and signals completion with a one-cycle done pulse. The ALU top-level muxes its registered outputs alongside the add and multiply results.

---
 rtl/alu_pkg.sv | 15 +
 rtl/div_step.sv | 33 +++
 rtl/division.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default datapath width and
// the quotient reported for a zero divisor.
package alu_pkg;

  localparam int WIDTH = 8;

  localparam logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try the
// subtraction, and keep it only if it does not go negative.
module div_step
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] q,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shifted_s;
  logic [W:0] diff_s;

  // The partial remainder is W+1 bits wide only during the trial subtraction;
  // after restore it is always below the divisor, so the top bit is zero.
  always_comb begin
    shifted_s = {1'b0, rem[W-2:0], q[W-1]};
    shifted_s[W] = rem[W-1];
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[W] == 1'b0) begin
      rem_next = diff_s[W-1:0];
      q_next   = {q[W-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[W-1:0];
      q_next   = {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/division.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// registered and flagged with a single-cycle done pulse.
module division
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q_Out,
  output logic [W-1:0] R_Out,
  output logic         DivByZero,
  output logic         busy,
  output logic         done
);

  localparam int CNT_W = $clog2(W);

  div_state_e       state_r;
  logic [CNT_W-1:0] count_r;
  logic [W-1:0]     rem_r;
  logic [W-1:0]     q_r;
  logic [W-1:0]     divisor_r;
  logic [W-1:0]     rem_next_s;
  logic [W-1:0]     q_next_s;

  div_step #(.W(W)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (divisor_r),
    .rem_next (rem_next_s),
    .q_next   (q_next_s)
  );

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      divisor_r <= '0;
      Q_Out     <= '0;
      R_Out     <= '0;
      DivByZero <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_r       <= A;
            divisor_r <= B;
            rem_r     <= '0;
            count_r   <= '0;
            DivByZero <= 1'b0;
            busy      <= 1'b1;
            if (B == {W{1'b0}}) begin
              Q_Out     <= DIV0_QUOT[W-1:0];
              R_Out     <= A;
              DivByZero <= 1'b1;
              done      <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r   <= RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          if (count_r == CNT_W'(W - 1)) begin
            Q_Out   <= q_next_s;
            R_Out   <= rem_next_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
